// File: rtl/irq_pc_seq_pkg.sv
//
// irq_pc_seq_pkg
// Shared definitions for the interrupt PC sequencer.
//   - PC pre-control codes consumed by the PC generator
//     (PC_IGN / PC_KEP / PC_IRQ / PC_RST)
//   - sequencer state encoding (S_RST / S_RUN / S_FLUSH / S_VEC / S_ISR)
//   - helpers that map a state to its pre-control code and
//     compute a vector address
//
`timescale 1ns/1ps

package irq_pc_seq_pkg;

    // Pre-control codes. These values are already decoded by the PC generator.
    localparam logic [3:0] PC_IGN = 4'b0000;
    localparam logic [3:0] PC_KEP = 4'b0001;
    localparam logic [3:0] PC_IRQ = 4'b0010;
    localparam logic [3:0] PC_RST = 4'b0100;

    typedef enum logic [2:0] {
        S_RST   = 3'd0,
        S_RUN   = 3'd1,
        S_FLUSH = 3'd2,
        S_VEC   = 3'd3,
        S_ISR   = 3'd4
    } state_t;

    // Each state drives exactly one pre-control code.
    function automatic logic [3:0] state_prectl(input state_t s);
        logic [3:0] code;
        code = PC_IGN;
        case (s)
            S_RST:   code = PC_RST;
            S_FLUSH: code = PC_KEP;
            S_VEC:   code = PC_IRQ;
            default: code = PC_IGN;
        endcase
        return code;
    endfunction

    // Vector address of line idx; the sum wraps at 32 bits.
    function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                             input logic [2:0]  idx,
                                             input int unsigned stride);
        return base + (32'(idx) * 32'(stride));
    endfunction

endpackage

// File: rtl/irq_pc_seq_prio.sv
//
// irq_prio_enc
// Fixed-priority encoder; the lowest set index wins. Purely combinational.
// Ports:
//   req    in  N  request vector (already masked by the caller)
//   valid  out 1  at least one request present
//   idx    out 3  index of the winning request
//
`timescale 1ns/1ps

module irq_prio_enc #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    output logic         valid,
    output logic [2:0]   idx
);

    // Scan from the top down so the lowest set bit is the last writer.
    always_comb begin
        valid = 1'b0;
        idx   = 3'd0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = 3'(i);
            end
        end
    end

endmodule

// File: rtl/irq_pc_seq.sv
//
// irq_pc_seq
// Drives the PC pre-control code into the PC generator: holds PC_RST after
// reset, drains the pipeline with PC_KEP before vectoring, issues PC_IRQ with
// the vector address, and tracks the handler until eret.
//
// Configuration macro: IRQ_EDGE_EN
//   defined   - requests are rising-edge triggered and held in a pending
//               register until acknowledged (edges during a handler are kept)
//   undefined - requests are level-sensitive with no pending storage
//
// Ports:
//   clk        in  1     system clock
//   rst        in  1     asynchronous active-high reset
//   pause      in  1     global stall; freezes the sequencer
//   irq_req    in  NIRQ  interrupt request lines
//   irq_en     in  NIRQ  per-line enable mask
//   in_dslot   in  1     fetch-stage instruction is a delay slot
//   eret       in  1     return-from-interrupt decoded this cycle
//   pc_i       in  32    current PC
//   pc_prectl  out 4     PC pre-control code
//   irq_addr   out 32    vector address to the PC generator
//   zz_spc     out 32    saved return PC
//   irq_ack    out NIRQ  one-hot, one-cycle acknowledge
//   in_isr     out 1     handler active
//
`timescale 1ns/1ps

module irq_pc_seq
    import irq_pc_seq_pkg::*;
#(
    parameter int          NIRQ         = 4,
    parameter int          RST_CYCLES   = 4,
    parameter int          FLUSH_CYCLES = 3,
    parameter logic [31:0] IRQ_BASE     = 32'h0000_0050,
    parameter int          VEC_STRIDE   = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pause,
    input  logic [NIRQ-1:0] irq_req,
    input  logic [NIRQ-1:0] irq_en,
    input  logic            in_dslot,
    input  logic            eret,
    input  logic [31:0]     pc_i,
    output logic [3:0]      pc_prectl,
    output logic [31:0]     irq_addr,
    output logic [31:0]     zz_spc,
    output logic [NIRQ-1:0] irq_ack,
    output logic            in_isr
);

    localparam int CNT_MAX = (RST_CYCLES > FLUSH_CYCLES) ? RST_CYCLES : FLUSH_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [2:0]        idx_q, idx_next;
    logic [31:0]       spc_next;
    logic [31:0]       addr_next;
    logic [NIRQ-1:0]   ack_next;
    logic [NIRQ-1:0]   pend;
    logic [NIRQ-1:0]   ack_onehot;
    logic              win_valid;
    logic [2:0]        win_idx;

`ifdef IRQ_EDGE_EN
    logic [NIRQ-1:0] req_prev;
    logic [NIRQ-1:0] pend_q;

    // Edge-triggered pending bits. The edge detector keeps running during
    // pause and during a handler so that no edge is missed; a bit clears
    // when its acknowledge is on the output, and a fresh edge wins over it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_prev <= '0;
            pend_q   <= '0;
        end else begin
            req_prev <= irq_req;
            pend_q   <= (pend_q & ~irq_ack) | (irq_req & ~req_prev);
        end
    end

    assign pend = pend_q;
`else
    // Level-sensitive: a line counts only while it is held high.
    assign pend = irq_req;
`endif

    irq_prio_enc #(
        .N (NIRQ)
    ) u_prio (
        .req   (pend & irq_en),
        .valid (win_valid),
        .idx   (win_idx)
    );

    // Acknowledge pattern for the latched winner.
    always_comb begin
        ack_onehot = '0;
        for (int k = 0; k < NIRQ; k++) begin
            ack_onehot[k] = (idx_q == 3'(k));
        end
    end

    // Next-state logic. Under pause nothing advances and the acknowledge
    // falls to zero. S_VEC only moves on once an acknowledge has actually
    // been on the output in an unpaused cycle, so an ack cut short by pause
    // gets re-issued when pause drops.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx_q;
        spc_next   = zz_spc;
        addr_next  = irq_addr;
        ack_next   = '0;
        if (!pause) begin
            case (state)
                S_RST: begin
                    if (cnt == CNT_W'(RST_CYCLES - 1)) begin
                        state_next = S_RUN;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    if (win_valid && !in_dslot) begin
                        idx_next   = win_idx;
                        spc_next   = pc_i;
                        cnt_next   = '0;
                        state_next = S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (cnt == CNT_W'(FLUSH_CYCLES - 1)) begin
                        state_next = S_VEC;
                        cnt_next   = '0;
                        addr_next  = vec_addr(IRQ_BASE, idx_q, VEC_STRIDE);
                        ack_next   = ack_onehot;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                S_VEC: begin
                    if (irq_ack != '0) begin
                        state_next = S_ISR;
                    end else begin
                        addr_next = vec_addr(IRQ_BASE, idx_q, VEC_STRIDE);
                        ack_next  = ack_onehot;
                    end
                end
                S_ISR: begin
                    if (eret) begin
                        state_next = S_RUN;
                    end
                end
                default: begin
                    state_next = S_RST;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // State and output registers. pc_prectl and in_isr are registered from
    // the next state, so they always describe the state currently held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_RST;
            cnt       <= '0;
            idx_q     <= 3'd0;
            zz_spc    <= 32'd0;
            irq_addr  <= IRQ_BASE;
            irq_ack   <= '0;
            pc_prectl <= PC_RST;
            in_isr    <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            idx_q     <= idx_next;
            zz_spc    <= spc_next;
            irq_addr  <= addr_next;
            irq_ack   <= ack_next;
            pc_prectl <= state_prectl(state_next);
            in_isr    <= (state_next == S_ISR);
        end
    end

endmodule
